// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a one-entry skid buffer so id_ready is registered
// and never depends combinationally on ex_ready. Also counts backpressure cycles.
module id_ex_skid #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ALUOP_W  = 8,
  parameter int unsigned ALUSEL_W = 3,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [DATA_W-1:0]   id_reg1,
  input  logic [DATA_W-1:0]   id_reg2,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [ADDR_W-1:0]   id_shamt,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [DATA_W-1:0]   ex_reg1,
  output logic [DATA_W-1:0]   ex_reg2,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [ADDR_W-1:0]   ex_shamt,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned PW = ALUOP_W + ALUSEL_W + 3 * DATA_W + 2 * ADDR_W + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e        state_q;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] in_pld;
  logic          accept;
  logic          xfer;

  assign in_pld = {id_aluop, id_alusel, id_reg1, id_reg2, id_imm, id_shamt, id_wd, id_wreg};
  // An all-zero main register is exactly the NOP payload.
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_imm, ex_shamt, ex_wd, ex_wreg} = main_q;

  assign accept = id_valid & id_ready;
  assign xfer   = ex_valid & ex_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      id_ready  <= 1'b1;
      ex_valid  <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else begin
      // Backpressure count survives flush.
      if (ex_valid && !ex_ready && stall_cnt != CntMax) begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (flush) begin
        state_q  <= StEmpty;
        id_ready <= 1'b1;
        ex_valid <= 1'b0;
        main_q   <= '0;
        skid_q   <= '0;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              main_q   <= in_pld;
              state_q  <= StFull;
              ex_valid <= 1'b1;
            end
          end
          StFull: begin
            if (accept && xfer) begin
              main_q <= in_pld;
            end else if (accept) begin
              skid_q   <= in_pld;
              state_q  <= StSkid;
              id_ready <= 1'b0;
            end else if (xfer) begin
              main_q   <= '0;
              state_q  <= StEmpty;
              ex_valid <= 1'b0;
            end
          end
          StSkid: begin
            if (xfer) begin
              main_q   <= skid_q;
              state_q  <= StFull;
              id_ready <= 1'b1;
            end
          end
          default: begin
            state_q  <= StEmpty;
            id_ready <= 1'b1;
            ex_valid <= 1'b0;
            main_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
